// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arbiter_pkg;

  localparam int DEFAULT_WIDTH_DATA = 32;
  localparam int DEFAULT_DEPTH      = 5;

  localparam int NUM_REQ = 2;
  localparam int REQ0    = 0;
  localparam int REQ1    = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle for mem_arbiter.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int WIDTH_DATA = DEFAULT_WIDTH_DATA,
  parameter int DEPTH      = DEFAULT_DEPTH
);

  logic                  req0_valid;
  logic                  req0_we;
  logic [DEPTH-1:0]      req0_addr;
  logic [WIDTH_DATA-1:0] req0_wdata;
  logic                  req0_ready;
  logic                  rsp0_valid;
  logic [WIDTH_DATA-1:0] rsp0_rdata;

  logic                  req1_valid;
  logic                  req1_we;
  logic [DEPTH-1:0]      req1_addr;
  logic [WIDTH_DATA-1:0] req1_wdata;
  logic                  req1_ready;
  logic                  rsp1_valid;
  logic [WIDTH_DATA-1:0] rsp1_rdata;

  logic                  mem_read_enable;
  logic                  mem_write_enable;
  logic [DEPTH-1:0]      mem_address;
  logic [WIDTH_DATA-1:0] mem_data_in;
  logic [WIDTH_DATA-1:0] mem_data_out;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output mem_read_enable, mem_write_enable, mem_address, mem_data_in,
    input  mem_data_out
  );

  // Requesters plus memory environment
  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  mem_read_enable, mem_write_enable, mem_address, mem_data_in,
    output mem_data_out
  );

endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, contention goes to the one not served last.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // 1 means requester 1 was served last, so requester 0 wins the first tie
  logic last_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg <= 1'b1;
    end else if (advance) begin
      last_reg <= gnt[REQ1];
    end
  end

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_reg ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto one single-port memory, one transaction in flight at a time.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WIDTH_DATA = DEFAULT_WIDTH_DATA,
  parameter int DEPTH      = DEFAULT_DEPTH
)(
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  state_t state_reg, state_next;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_we;
  logic [DEPTH-1:0]      req_addr  [NUM_REQ];
  logic [WIDTH_DATA-1:0] req_wdata [NUM_REQ];
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [WIDTH_DATA-1:0] rsp_rdata [NUM_REQ];
  logic                  accept;
  logic                  sel;

  logic                  owner_reg;
  logic                  we_reg;
  logic [DEPTH-1:0]      addr_reg;
  logic [WIDTH_DATA-1:0] wdata_reg;
  logic                  rd_en;
  logic                  wr_en;

  assign req_valid    = {bus.req1_valid, bus.req0_valid};
  assign req_we       = {bus.req1_we, bus.req0_we};
  assign req_addr[0]  = bus.req0_addr;
  assign req_addr[1]  = bus.req1_addr;
  assign req_wdata[0] = bus.req0_wdata;
  assign req_wdata[1] = bus.req1_wdata;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (accept),
    .gnt     (gnt)
  );

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      // Ready is also gated by reset so nothing looks accepted while held in reset
      assign ready[gi]     = rst_n && (state_reg == IDLE) && gnt[gi];
      assign rsp_valid[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));
      assign rsp_rdata[gi] = (rsp_valid[gi] && !we_reg) ? bus.mem_data_out : '0;
    end
  endgenerate

  assign accept = |ready;
  assign sel    = gnt[REQ1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_reg <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else if (accept) begin
      owner_reg <= sel;
      we_reg    <= req_we[sel];
      addr_reg  <= req_addr[sel];
      wdata_reg <= req_wdata[sel];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = CMD;
      end
      CMD: begin
        rd_en      = !we_reg;
        wr_en      = we_reg;
        state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.mem_read_enable  = rd_en;
  assign bus.mem_write_enable = wr_en;
  assign bus.mem_address      = addr_reg;
  assign bus.mem_data_in      = wdata_reg;

  assign bus.req0_ready = ready[REQ0];
  assign bus.req1_ready = ready[REQ1];
  assign bus.rsp0_valid = rsp_valid[REQ0];
  assign bus.rsp1_valid = rsp_valid[REQ1];
  assign bus.rsp0_rdata = rsp_rdata[REQ0];
  assign bus.rsp1_rdata = rsp_rdata[REQ1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 1-cycle registered-read memory model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.WIDTH_DATA(32), .DEPTH(5)) bus ();

  mem_arbiter #(.WIDTH_DATA(32), .DEPTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [32];
  bit          mem_init = 1'b0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          rsp1_cnt = 0;
  bit          both_en = 1'b0;

  int passed = 0;
  int total = 0;

  // Memory model: writes win over reads, reads are registered
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hA5A50000 | 32'(i);
      mem_init <= 1'b1;
    end else if (bus.mem_write_enable) begin
      mem[bus.mem_address] <= bus.mem_data_in;
    end else if (bus.mem_read_enable) begin
      bus.mem_data_out <= mem[bus.mem_address];
    end
    if (bus.mem_write_enable) wr_cnt <= wr_cnt + 1;
    if (bus.mem_read_enable) rd_cnt <= rd_cnt + 1;
    if (bus.mem_write_enable && bus.mem_read_enable) both_en <= 1'b1;
    if (bus.rsp1_valid) rsp1_cnt <= rsp1_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
    total++;
    assert (obs === exp_val) begin
      passed++;
    end else begin
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_val);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_we = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
    bus.req1_valid = 1'b0; bus.req1_we = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r0;
    int w0;
    int s1;
    logic gnt_seq [12];
    int   cyc_seq [12];

    idle_inputs();
    bus.req0_valid = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_ready0",   32'(bus.req0_ready), 0);
    check("rst_rd_en",    32'(bus.mem_read_enable), 0);
    check("rst_wr_en",    32'(bus.mem_write_enable), 0);
    check("rst_addr",     32'(bus.mem_address), 0);
    check("rst_data_in",  bus.mem_data_in, 0);
    check("rst_rsp0",     32'(bus.rsp0_valid), 0);
    check("rst_rsp1",     32'(bus.rsp1_valid), 0);
    bus.req0_valid = 1'b0;
    rst_n = 1'b1;

    // req0 writes DEADBEEF to address 3
    bus.req0_valid = 1'b1; bus.req0_we = 1'b1; bus.req0_addr = 5'd3; bus.req0_wdata = 32'hDEADBEEF;
    #1;
    check("wr_ready0", 32'(bus.req0_ready), 1);
    check("wr_ready1", 32'(bus.req1_ready), 0);
    tick();
    idle_inputs();
    check("wr_cmd_wr_en", 32'(bus.mem_write_enable), 1);
    check("wr_cmd_rd_en", 32'(bus.mem_read_enable), 0);
    check("wr_cmd_addr",  32'(bus.mem_address), 3);
    check("wr_cmd_data",  bus.mem_data_in, 32'hDEADBEEF);
    check("wr_cmd_ready", 32'(bus.req0_ready), 0);
    tick();
    check("wr_rsp0_valid", 32'(bus.rsp0_valid), 1);
    check("wr_rsp0_rdata", bus.rsp0_rdata, 0);
    check("wr_rsp1_valid", 32'(bus.rsp1_valid), 0);
    check("wr_resp_wr_en", 32'(bus.mem_write_enable), 0);
    check("wr_resp_addr",  32'(bus.mem_address), 3);
    tick();
    check("wr_after_rsp0", 32'(bus.rsp0_valid), 0);

    // req0 reads address 3 back
    bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 5'd3;
    tick();
    idle_inputs();
    check("rd_cmd_rd_en", 32'(bus.mem_read_enable), 1);
    check("rd_cmd_wr_en", 32'(bus.mem_write_enable), 0);
    check("rd_cmd_addr",  32'(bus.mem_address), 3);
    tick();
    check("rd_rsp0_valid", 32'(bus.rsp0_valid), 1);
    check("rd_rsp0_rdata", bus.rsp0_rdata, 32'hDEADBEEF);
    tick();
    check("rd_after_rsp0",   32'(bus.rsp0_valid), 0);
    check("rd_after_rdata0", bus.rsp0_rdata, 0);

    // Simultaneous reads right after reset: req0 first, req1 three cycles later
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 5'd3;
    bus.req1_valid = 1'b1; bus.req1_we = 1'b0; bus.req1_addr = 5'd5;
    #1;
    check("sim_ready0", 32'(bus.req0_ready), 1);
    check("sim_ready1", 32'(bus.req1_ready), 0);
    tick();
    bus.req0_valid = 1'b0;
    #1;
    check("sim_cmd_ready1", 32'(bus.req1_ready), 0);
    tick();
    check("sim_rsp0_valid", 32'(bus.rsp0_valid), 1);
    check("sim_rsp1_quiet", 32'(bus.rsp1_valid), 0);
    check("sim_rsp0_rdata", bus.rsp0_rdata, 32'hDEADBEEF);
    check("sim_resp_ready1", 32'(bus.req1_ready), 0);
    tick();
    check("sim_idle_ready1", 32'(bus.req1_ready), 1);
    tick();
    bus.req1_valid = 1'b0;
    check("sim1_cmd_rd_en", 32'(bus.mem_read_enable), 1);
    check("sim1_cmd_addr",  32'(bus.mem_address), 5);
    tick();
    check("sim_rsp1_valid", 32'(bus.rsp1_valid), 1);
    check("sim_rsp0_quiet", 32'(bus.rsp0_valid), 0);
    check("sim_rsp1_rdata", bus.rsp1_rdata, 32'hA5A50005);
    tick();

    // Both held valid for 12 cycles: expect 0,1,0,1 every 3 cycles
    bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 5'd3;
    bus.req1_valid = 1'b1; bus.req1_we = 1'b0; bus.req1_addr = 5'd5;
    #1;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.req0_ready || bus.req1_ready) begin
        gnt_seq[n] = bus.req1_ready;
        cyc_seq[n] = c;
        n++;
      end
      tick();
    end
    idle_inputs();
    check("rr_accepts", 32'(n), 4);
    check("rr_gnt0", 32'(gnt_seq[0]), 0);
    check("rr_gnt1", 32'(gnt_seq[1]), 1);
    check("rr_gnt2", 32'(gnt_seq[2]), 0);
    check("rr_gnt3", 32'(gnt_seq[3]), 1);
    check("rr_cyc1", 32'(cyc_seq[1]), 3);
    check("rr_cyc3", 32'(cyc_seq[3]), 9);

    // req1 write to 31 aborted by reset during CMD
    bus.req1_valid = 1'b1; bus.req1_we = 1'b1; bus.req1_addr = 5'd31; bus.req1_wdata = 32'h12345678;
    #1;
    check("abort_ready1", 32'(bus.req1_ready), 1);
    w0 = wr_cnt;
    tick();
    idle_inputs();
    check("abort_cmd_wr_en", 32'(bus.mem_write_enable), 1);
    check("abort_cmd_addr",  32'(bus.mem_address), 31);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_rst_wr_en", 32'(bus.mem_write_enable), 0);
    check("abort_rst_addr",  32'(bus.mem_address), 0);
    tick();
    check("abort_rsp1",   32'(bus.rsp1_valid), 0);
    check("abort_no_wr",  32'(wr_cnt), 32'(w0));
    rst_n = 1'b1;
    bus.req1_valid = 1'b1; bus.req1_we = 1'b0; bus.req1_addr = 5'd31;
    tick();
    idle_inputs();
    tick();
    check("abort_rd_valid", 32'(bus.rsp1_valid), 1);
    check("abort_rd_rdata", bus.rsp1_rdata, 32'hA5A5001F);
    tick();

    // req1 pulses valid for one cycle while req0 is in CMD
    r0 = rd_cnt;
    s1 = rsp1_cnt;
    bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 5'd5;
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_we = 1'b0; bus.req1_addr = 5'd7;
    #1;
    check("pulse_ready1", 32'(bus.req1_ready), 0);
    tick();
    bus.req1_valid = 1'b0;
    check("pulse_rsp0_valid", 32'(bus.rsp0_valid), 1);
    check("pulse_rsp0_rdata", bus.rsp0_rdata, 32'hA5A50005);
    check("pulse_rsp1_quiet", 32'(bus.rsp1_valid), 0);
    tick();
    check("pulse_idle_ready1", 32'(bus.req1_ready), 0);
    tick();
    check("pulse_rd_count",  32'(rd_cnt), 32'(r0 + 1));
    check("pulse_rsp1_count", 32'(rsp1_cnt), 32'(s1));

    // req1 write response carries zero data
    bus.req1_valid = 1'b1; bus.req1_we = 1'b1; bus.req1_addr = 5'd10; bus.req1_wdata = 32'hCAFEF00D;
    tick();
    idle_inputs();
    tick();
    check("wr1_rsp1_valid", 32'(bus.rsp1_valid), 1);
    check("wr1_rsp1_rdata", bus.rsp1_rdata, 0);
    tick();
    check("no_dual_enable", 32'(both_en), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH_DATA, default 32, meaning the data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 5, meaning the address width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have, for requester i in {0,1}, port reqi_valid, input, 1 bit: request pending.
REQ-006 The block SHALL have port reqi_we, input, 1 bit: 1 = write, 0 = read.
REQ-007 The block SHALL have port reqi_addr, input, DEPTH bits: target address.
REQ-008 The block SHALL have port reqi_wdata, input, WIDTH_DATA bits: write data.
REQ-009 The block SHALL have port reqi_ready, output, 1 bit: request accepted this cycle.
REQ-010 The block SHALL have port rspi_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port rspi_rdata, output, WIDTH_DATA bits: read data, valid only while rspi_valid is high.
REQ-012 The block SHALL have port mem_read_enable, output, 1 bit; mem_write_enable, output, 1 bit; mem_address, output, DEPTH bits; mem_data_in, output, WIDTH_DATA bits; mem_data_out, input, WIDTH_DATA bits. These connect to the single-port memory, which has 1-cycle registered reads and gives writes priority.

Function
REQ-013 The FSM SHALL have states IDLE, CMD and RESP, with transitions IDLE->CMD on accept, CMD->RESP always, and RESP->IDLE always.
REQ-014 A request SHALL be accepted on a rising edge where reqi_valid and reqi_ready are both high; only one transaction is outstanding at a time.
REQ-015 reqi_ready SHALL be combinational and high only in IDLE, for the granted requester, while reqi_valid is high; it SHALL never be high for both requesters.
REQ-016 Arbitration SHALL be round-robin: with one requester valid, that requester is granted; with both valid, the requester not served last is granted; the last-served pointer updates on accept.
REQ-017 On accept, the block SHALL register the request's address, write data, we flag and owner, and enter CMD on the next cycle.
REQ-018 In CMD, exactly one of mem_read_enable or mem_write_enable SHALL be high, per the registered we flag, for exactly one cycle; both enables SHALL be low in every other state.
REQ-019 mem_address and mem_data_in SHALL be registered and SHALL hold their last value outside CMD.
REQ-020 In RESP, rspi_valid SHALL be high for the owner only; for a read, rspi_rdata = mem_data_out; for a write, rspi_rdata = 0. Outside RESP, rspi_valid = 0 and rspi_rdata = 0.
REQ-021 Latency SHALL be as follows: for a request accepted at edge N, the enable is high in cycle N+1, the response in cycle N+2, and the next accept is possible at earliest edge N+3.
REQ-022 A requester SHALL hold valid, we, addr and wdata stable until accepted; the block does not check this.
REQ-023 If reqi_valid drops before acceptance, the block SHALL drop the request with no side effect.
REQ-024 A requester asserting a new request during its own RESP cycle SHALL be arbitrated normally from the following IDLE cycle.

Reset
REQ-025 While rst_n = 0, the block SHALL asynchronously force: state = IDLE; last-served pointer = requester 1, so requester 0 wins the first contention; mem_read_enable = mem_write_enable = 0; mem_address = 0; mem_data_in = 0; rsp0_valid = rsp1_valid = 0; reqi_ready = 0.
REQ-026 On reset during CMD or RESP, the block SHALL abort the transaction with no response; a write whose enable edge has not yet occurred SHALL not reach memory.

Structure
REQ-027 The shared package SHALL hold the state enum (IDLE/CMD/RESP), requester-index constants, and the default WIDTH_DATA/DEPTH values.
REQ-028 The round-robin grant logic SHALL be a separate sub-module named rr_arbiter2, with inputs req[1:0] and advance, and output gnt[1:0] one-hot or zero.
REQ-029 The memory instance SHALL be external to this block.

Verification
REQ-030 A bench SHALL cover: req0 writes 0xDEADBEEF to address 3, then reads address 3 -> write enable high at N+1 with addr 3; read returns rsp0_valid with 0xDEADBEEF two cycles after accept.
REQ-031 A bench SHALL cover: req0 and req1 read simultaneously after reset -> req0 granted first, req1 accepted 3 cycles later; each rsp pulse goes only to its owner.
REQ-032 A bench SHALL cover: both requesters held valid for 12 cycles -> grants alternate 0,1,0,1 with 4 accepts, one per 3 cycles.
REQ-033 A bench SHALL cover: req1 writes 0x12345678 to address 31, with reset asserted during CMD before the edge -> no response; a later read of address 31 returns its prior content.
REQ-034 A bench SHALL cover: req1_valid pulsed for one cycle while req0 is in CMD -> no accept, no response, no memory access for req1.
REQ-035 A bench SHALL cover: a write response -> rsp_rdata = 0 and both enables are never high together in any cycle.
